chan_req_encoder: RTL and testbench
===================================

# chan_req_encoder

Request-side driver for the 9-line channel interface consumed by the channel decoder. It queues channel service requests (indices 0..7) into a pending mask and drives the interface lines: I[8] is the active-high enable and I[7:0] are active-low request lines. The decoder reports the highest pending channel as Chan = {1, index}; this block checks each service acknowledge against that report and retires the serviced channel. After each retirement it drops enable for a fixed gap.

## Interface
- GAP_CYCLES, 2: cycles I[8] is held low after each retirement; legal range 1..15.
- AGE_LIMIT, 15: consecutive unserviced ASSERT cycles before Stall sets; legal range 1..255.
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- Req_valid  in  1  request offered.
- Req_Chan  in  3  channel index of the offered request.
- Req_ready  out  1  request accepted when Req_valid && Req_ready.
- Ack  in  1  consumer has serviced the channel currently shown on Chan.
- Chan  in  4  decoder output fed back; Chan[3] is the any-request flag, Chan[2:0] is the index.
- I  out  9  interface lines: I[8] is enable, I[7:0] are active-low requests.
- Pending  out  8  pending mask P.
- Ack_err  out  1  one-cycle pulse on an invalid acknowledge.
- Stall  out  1  sticky watchdog flag.

## Operation
- State: P[7:0], FSM {IDLE, ASSERT, GAP}, 4-bit gap counter, 8-bit saturating age counter.
- I[7:0] = ~P. I[8] = 1 only in ASSERT.
- Req_ready = (P != 8'hFF) && !rst.
- An accept sets P[Req_Chan]. A duplicate of an already-set bit is accepted and causes no change.
- top = index of the highest set bit of P. A valid ack is: state ASSERT, Ack=1, and Chan == {1'b1, top}.
- IDLE:
  - Go to ASSERT if P != 0 or an accept occurs this cycle.
  - Otherwise stay in IDLE.
- ASSERT, valid ack:
  - Clear P[top].
  - Load the gap counter with GAP_CYCLES and go to GAP.
  - Reset the age counter.
- ASSERT, Ack=1 but not valid (Chan[3]=0 or index mismatch):
  - Pulse Ack_err.
  - P and state are unchanged.
- Ack=1 in IDLE or GAP: pulse Ack_err, otherwise ignored.
- GAP:
  - Decrement the gap counter each cycle.
  - On the cycle the counter reads 1, go to ASSERT if P != 0 or an accept occurs this cycle; otherwise go to IDLE.
- Accept and retire of the same bit in one cycle: the accept wins and the bit stays set (new request).
- Age counter:
  - Increments each ASSERT cycle without a valid ack, saturating at 255.
  - Cleared on a valid ack or on leaving ASSERT.
  - Stall sets when the counter reaches AGE_LIMIT and holds until rst.

## Timing
- Reset values: P=0, FSM=IDLE, I=9'h0FF, Pending=0, Ack_err=0, Stall=0, counters 0, Req_ready=0 while rst is high.
- rst asserted mid-ASSERT or mid-GAP: all reset values appear at the next edge; Req_valid and Ack in that cycle are ignored.
- I, Pending, Ack_err and Stall are registered. Req_ready is combinational from P.
- Latency from accept to request lines: an accept at edge n drives I[Req_Chan]=0 and I[8]=1 after edge n+1 when starting from IDLE.
- Ack and Chan are sampled in the same cycle.
- After a valid ack at edge n:
  - P updates and I[8]=0 after edge n+1.
  - I[8] returns to 1 after edge n+1+GAP_CYCLES if P != 0.
- Ack_err is high for exactly the cycle after the offending Ack.
- Stall rises after the edge that ends the AGE_LIMIT-th consecutive unserviced ASSERT cycle.

## Test plan
1. Assert rst for 2 cycles -> I=9'h0FF, Pending=8'h00, Stall=0, Ack_err=0; after release Req_ready=1.
2. Accept Req_Chan=5 -> next cycle I=9'h1DF. Then Ack with Chan=4'hD -> I=9'h0FF, Pending=0, FSM back to IDLE after the 2-cycle gap.
3. Accept channels 2 and 6 -> I=9'h1BB. Ack with Chan=4'hE clears bit 6 -> I=9'h0FB for 2 cycles, then I=9'h1FB.
4. With P=8'h44, Ack with Chan=4'hA (index mismatch) -> Ack_err pulses one cycle, Pending stays 8'h44. Repeat with Chan=4'h0 -> same result.
5. Hold ch3 pending with no Ack, AGE_LIMIT=15 -> Stall=1 after the 15th ASSERT cycle. A later valid ack retires ch3 but Stall remains 1.
6. Accept all 8 channels -> Pending=8'hFF, I=9'h100, Req_ready=0. Assert rst during ASSERT -> next cycle I=9'h0FF, Pending=0, Stall=0.

Source files
------------

// File: rtl/chan_req_encoder.sv
// Request-side driver for the 9-line channel interface.
// Queues channel requests, checks decoder acknowledges and retires them.
module chan_req_encoder #(
  parameter int GAP_CYCLES = 2,
  parameter int AGE_LIMIT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Req_valid,
  input  logic [2:0] Req_Chan,
  output logic       Req_ready,
  input  logic       Ack,
  input  logic [3:0] Chan,
  output logic [8:0] I,
  output logic [7:0] Pending,
  output logic       Ack_err,
  output logic       Stall
);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] age_q, age_d;
  logic       ack_err_q, ack_err_d;
  logic       stall_q, stall_d;

  logic       accept;
  logic       valid_ack;
  logic [2:0] top;

  always_comb begin
    top = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p_q[i]) top = i[2:0];
    end
  end

  assign Req_ready = (p_q != 8'hFF) && !rst;
  assign accept    = Req_valid && Req_ready;
  assign valid_ack = (state_q == ASSERT) && Ack &&
                     (p_q != 8'h00) && (Chan == {1'b1, top});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= 8'h00;
      gap_q     <= 4'd0;
      age_q     <= 8'd0;
      ack_err_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      gap_q     <= gap_d;
      age_q     <= age_d;
      ack_err_q <= ack_err_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((p_q != 8'h00) || accept) state_d = ASSERT;
      end
      ASSERT: begin
        if (valid_ack) state_d = GAP;
      end
      GAP: begin
        if (gap_q == 4'd1) begin
          state_d = ((p_q != 8'h00) || accept) ? ASSERT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept is applied after retire so a same-cycle re-request survives.
  always_comb begin
    p_d = p_q;
    if (valid_ack) p_d[top] = 1'b0;
    if (accept) p_d[Req_Chan] = 1'b1;

    gap_d = gap_q;
    if (valid_ack) begin
      gap_d = 4'(GAP_CYCLES);
    end else if (state_q == GAP && gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    age_d = 8'd0;
    if (state_q == ASSERT && !valid_ack) begin
      age_d = (age_q == 8'hFF) ? age_q : age_q + 8'd1;
    end

    ack_err_d = Ack && !valid_ack;
    stall_d   = stall_q || (age_d == 8'(AGE_LIMIT));
  end

  always_comb begin
    I       = {state_q == ASSERT, ~p_q};
    Pending = p_q;
    Ack_err = ack_err_q;
    Stall   = stall_q;
  end

endmodule

// File: tb/tb_chan_req_encoder.sv
// Randomized scoreboard bench for chan_req_encoder against a
// behavioural model of the pending set, phases and watchdog.
module tb_chan_req_encoder;

  localparam int GAP = 2;
  localparam int LIM = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Req_valid = 1'b0;
  logic [2:0] Req_Chan = 3'd0;
  logic       Req_ready;
  logic       Ack = 1'b0;
  logic [3:0] Chan = 4'd0;
  logic [8:0] I;
  logic [7:0] Pending;
  logic       Ack_err;
  logic       Stall;

  chan_req_encoder #(.GAP_CYCLES(GAP), .AGE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .Req_valid(Req_valid), .Req_Chan(Req_Chan),
    .Req_ready(Req_ready), .Ack(Ack), .Chan(Chan), .I(I),
    .Pending(Pending), .Ack_err(Ack_err), .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] i;
    logic [7:0] pend;
    logic       err;
    logic       stall;
    logic       ready;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 0;

  // Model: set of pending channels, phase, gap cycles left, age count.
  bit   m_set[8];
  int   m_phase;
  int   m_gap_left;
  int   m_age;
  bit   m_err;
  bit   m_stall;

  function automatic logic [7:0] m_mask();
    logic [7:0] m = 8'h00;
    for (int k = 0; k < 8; k++) if (m_set[k]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic int m_top();
    for (int k = 7; k >= 0; k--) if (m_set[k]) return k;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 8; k++) if (m_set[k]) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_set[k] = 0;
    m_phase = 0;
    m_gap_left = 0;
    m_age = 0;
    m_err = 0;
    m_stall = 0;
  endtask

  task automatic m_step(bit r, bit rv, int rc, bit a, logic [3:0] ch);
    bit full, acc, ok, had;
    int t;
    if (r) begin
      m_reset();
      return;
    end
    full = (m_count() == 8);
    acc  = rv && !full;
    t    = m_top();
    ok   = (m_phase == 1) && a && t >= 0 && ch[3] && (int'(ch[2:0]) == t);
    m_err = a && !ok;
    had = (m_count() != 0) || acc;
    if (ok) m_set[t] = 0;
    if (acc) m_set[rc] = 1;
    case (m_phase)
      0: if (had) m_phase = 1;
      1: begin
        if (ok) begin
          m_phase = 2;
          m_gap_left = GAP;
          m_age = 0;
        end else begin
          if (m_age < 255) m_age++;
          if (m_age >= LIM) m_stall = 1;
        end
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = had ? 1 : 0;
      end
    endcase
  endtask

  task automatic cyc(bit r, bit rv, int rc, bit a, logic [3:0] ch);
    exp_t e;
    @(negedge clk);
    rst = r;
    Req_valid = rv;
    Req_Chan = 3'(rc);
    Ack = a;
    Chan = ch;
    #1;
    e.i = {m_phase == 1, ~m_mask()};
    e.pend = m_mask();
    e.err = m_err;
    e.stall = m_stall;
    e.ready = (m_count() != 8) && !r;
    q.push_back(e);
    m_step(r, rv, rc, a, ch);
  endtask

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() == 0) begin
        if (!done) chk("scoreboard_empty", 0, 1);
      end else begin
        e = q.pop_front();
        chk("I", int'(I), int'(e.i));
        chk("Pending", int'(Pending), int'(e.pend));
        chk("Ack_err", int'(Ack_err), int'(e.err));
        chk("Stall", int'(Stall), int'(e.stall));
        chk("Req_ready", int'(Req_ready), int'(e.ready));
      end
    end
  end

  initial begin : driver
    int t;
    logic [3:0] ch;
    m_reset();
    cyc(1, 0, 0, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 0, 4'h0);
    // single request, valid ack, gap back to idle
    cyc(0, 1, 5, 0, 4'h0);
    cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, 4'hD);
    repeat (4) cyc(0, 0, 0, 0, 4'h0);
    // two requests, highest retired first
    cyc(0, 1, 2, 0, 4'h0);
    cyc(0, 1, 6, 0, 4'h0);
    cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, 4'hE);
    repeat (3) cyc(0, 0, 0, 0, 4'h0);
    // bad acks with P = 0x44
    cyc(0, 1, 6, 0, 4'h0);
    cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, 4'hA);
    cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, 4'h0);
    cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 1, 6, 0, 4'h0);
    cyc(1, 0, 0, 0, 4'h0);
    // watchdog on ch3
    cyc(0, 1, 3, 0, 4'h0);
    repeat (20) cyc(0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 1, 4'hB);
    repeat (4) cyc(0, 0, 0, 0, 4'h0);
    // fill all channels, then reset mid-ASSERT
    for (int k = 0; k < 8; k++) cyc(0, 1, k, 0, 4'h0);
    cyc(0, 1, 1, 0, 4'h0);
    cyc(1, 1, 2, 1, 4'hF);
    cyc(0, 0, 0, 0, 4'h0);
    // random traffic
    for (int n = 0; n < 2000; n++) begin
      t = m_top();
      ch = 4'($urandom_range(0, 15));
      if (t >= 0 && $urandom_range(0, 9) < 7) ch = {1'b1, 3'(t)};
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 7),
          $urandom_range(0, 99) < ((n % 400) < 60 ? 2 : 30),
          ch);
    end
    done = 1;
    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: simulation did not end, expected finish");
    $fatal(1);
  end

endmodule
